rdmx_recv_be: RTL and testbench

//  Receive-side back end of the RDMX path, the mirror of the transmit front end.
//  - Consumes three AXI-Stream inputs: target address, packet length in bytes, and packet data.
//  - Issues each packet as one AXI4 INCR write burst on a master port.
//  - Sits between the RDMX packet receiver and the AXI interconnect to memory.

---
 rtl/rdmx_recv_be_pkg.sv | 17 +
 rtl/rdmx_recv_be_if.sv | 53 +++++
 rtl/rdmx_strb_gen.sv | 12 +
 rtl/rdmx_recv_be.sv | 115 +++++++++++
 tb/tb_rdmx_recv_be.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rdmx_recv_be_pkg.sv
// rdmx_recv_be_pkg: shared AXI constants, FSM encoding and bus-geometry helpers for the RDMX receive back end
package rdmx_recv_be_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_DRAIN} state_t;

    function automatic int bpb(input int data_wbits);
        return data_wbits / 8;
    endfunction

    function automatic int log2_bpb(input int data_wbits);
        return $clog2(data_wbits / 8);
    endfunction

endpackage

// File: rtl/rdmx_recv_be_if.sv
// rdmx_recv_be_if: the three AXI-Stream inputs and the AXI4 write master port of the receive back end
interface rdmx_recv_be_if #(
    parameter int DATA_WBITS = 512,
    parameter int ADDR_WBITS = 64
);
    localparam int BPB = DATA_WBITS / 8;

    logic [ADDR_WBITS-1:0] AXIS_ADDR_TDATA;
    logic                  AXIS_ADDR_TVALID;
    logic                  AXIS_ADDR_TREADY;
    logic [15:0]           AXIS_PLEN_TDATA;
    logic                  AXIS_PLEN_TVALID;
    logic                  AXIS_PLEN_TREADY;
    logic [DATA_WBITS-1:0] AXIS_DATA_TDATA;
    logic                  AXIS_DATA_TLAST;
    logic                  AXIS_DATA_TVALID;
    logic                  AXIS_DATA_TREADY;
    logic [ADDR_WBITS-1:0] M_AXI_AWADDR;
    logic [7:0]            M_AXI_AWLEN;
    logic [2:0]            M_AXI_AWSIZE;
    logic [1:0]            M_AXI_AWBURST;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_WBITS-1:0] M_AXI_WDATA;
    logic [BPB-1:0]        M_AXI_WSTRB;
    logic                  M_AXI_WLAST;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;

    // master: the back end itself (stream sink, AXI write master)
    modport master (
        input  AXIS_ADDR_TDATA, AXIS_ADDR_TVALID, AXIS_PLEN_TDATA, AXIS_PLEN_TVALID,
               AXIS_DATA_TDATA, AXIS_DATA_TLAST, AXIS_DATA_TVALID,
               M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        output AXIS_ADDR_TREADY, AXIS_PLEN_TREADY, AXIS_DATA_TREADY,
               M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY
    );

    // slave: packet receiver plus memory interconnect surrounding the back end
    modport slave (
        output AXIS_ADDR_TDATA, AXIS_ADDR_TVALID, AXIS_PLEN_TDATA, AXIS_PLEN_TVALID,
               AXIS_DATA_TDATA, AXIS_DATA_TLAST, AXIS_DATA_TVALID,
               M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        input  AXIS_ADDR_TREADY, AXIS_PLEN_TREADY, AXIS_DATA_TREADY,
               M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY
    );

endinterface

// File: rtl/rdmx_strb_gen.sv
// rdmx_strb_gen: byte strobe for the final beat of a burst from the packet length remainder
module rdmx_strb_gen #(
    parameter int BPB = 64,
    parameter int LB  = $clog2(BPB)
) (
    input  logic [LB-1:0]  rem,
    output logic [BPB-1:0] strb
);

    assign strb = rem == '0 ? '1 : ~({BPB{1'b1}} << rem);

endmodule

// File: rtl/rdmx_recv_be.sv
// rdmx_recv_be: turns address/length/data AXI-Stream packets into single AXI4 INCR write bursts
module rdmx_recv_be
    import rdmx_recv_be_pkg::*;
#(
    parameter int DATA_WBITS = 512,
    parameter int ADDR_WBITS = 64,
    parameter int MAX_OUTST  = 8
) (
    input  logic          clk,
    input  logic          resetn,
    rdmx_recv_be_if.master bus,
    output logic [2:0]    err_status,
    output logic [15:0]   err_count
);

    localparam int BPB = bpb(DATA_WBITS);
    localparam int LB  = log2_bpb(DATA_WBITS);
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam logic [16:0] MAX_PLEN = 17'(256 * BPB);

    state_t                state;
    logic [ADDR_WBITS-1:0] awaddr;
    logic [7:0]            awlen;
    logic [7:0]            beat;
    logic [LB-1:0]         rem;
    logic [OW-1:0]         outst;
    logic [BPB-1:0]        last_strb;
    logic [16:0]           err_sum;
    logic take, awvalid, early, bready;
    logic plen_bad, wlast, w_hs, aw_hs, b_hs, bad_ev, frame_ev, bresp_ev;

    rdmx_strb_gen #(.BPB(BPB)) u_strb (.rem(rem), .strb(last_strb));

    assign plen_bad = bus.AXIS_PLEN_TDATA == 16'd0 || {1'b0, bus.AXIS_PLEN_TDATA} > MAX_PLEN;
    assign wlast    = beat == awlen;
    assign w_hs     = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
    assign aw_hs    = awvalid && bus.M_AXI_AWREADY;
    assign b_hs     = bus.M_AXI_BVALID && bready;
    assign bad_ev   = state == ST_IDLE && take && plen_bad;
    // TLAST must coincide with WLAST; anything else is a framing error, flagged once per packet
    assign frame_ev = state == ST_W && w_hs && !early && (wlast ? !bus.AXIS_DATA_TLAST : bus.AXIS_DATA_TLAST);
    assign bresp_ev = b_hs && bus.M_AXI_BRESP != AXI_RESP_OKAY;
    assign err_sum  = {1'b0, err_count} + 17'(bresp_ev) + 17'(frame_ev) + 17'(bad_ev);

    assign bus.AXIS_ADDR_TREADY = take;
    assign bus.AXIS_PLEN_TREADY = take;
    assign bus.AXIS_DATA_TREADY = state == ST_DRAIN || (state == ST_W && !early && bus.M_AXI_WREADY);
    assign bus.M_AXI_AWADDR     = awaddr;
    assign bus.M_AXI_AWLEN      = awlen;
    assign bus.M_AXI_AWSIZE     = 3'(LB);
    assign bus.M_AXI_AWBURST    = AXI_BURST_INCR;
    assign bus.M_AXI_AWVALID    = awvalid;
    // after an early TLAST the burst is padded with empty beats without touching the stream
    assign bus.M_AXI_WVALID     = state == ST_W && (early || bus.AXIS_DATA_TVALID);
    assign bus.M_AXI_WDATA      = early ? '0 : bus.AXIS_DATA_TDATA;
    assign bus.M_AXI_WSTRB      = early ? '0 : wlast ? last_strb : '1;
    assign bus.M_AXI_WLAST      = state == ST_W && wlast;
    assign bus.M_AXI_BREADY     = bready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            take    <= 1'b0;
            awvalid <= 1'b0;
            awaddr  <= '0;
            awlen   <= '0;
            rem     <= '0;
            beat    <= '0;
            early   <= 1'b0;
        end else begin
            take <= 1'b0;
            case (state)
                ST_IDLE: if (take) begin
                    awaddr  <= bus.AXIS_ADDR_TDATA;
                    awlen   <= 8'((bus.AXIS_PLEN_TDATA - 16'd1) >> LB);
                    rem     <= bus.AXIS_PLEN_TDATA[LB-1:0];
                    awvalid <= !plen_bad;
                    state   <= plen_bad ? ST_DRAIN : ST_AW;
                end else if (bus.AXIS_ADDR_TVALID && bus.AXIS_PLEN_TVALID && outst < OW'(MAX_OUTST)) begin
                    take <= 1'b1;
                end
                ST_AW: if (bus.M_AXI_AWREADY) begin
                    awvalid <= 1'b0;
                    beat    <= '0;
                    early   <= 1'b0;
                    state   <= ST_W;
                end
                ST_W: if (w_hs) begin
                    beat <= beat + 8'd1;
                    if (wlast)
                        state <= early || bus.AXIS_DATA_TLAST ? ST_IDLE : ST_DRAIN;
                    else if (bus.AXIS_DATA_TLAST)
                        early <= 1'b1;
                end
                ST_DRAIN: if (bus.AXIS_DATA_TVALID && bus.AXIS_DATA_TLAST) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bready     <= 1'b0;
            outst      <= '0;
            err_status <= '0;
            err_count  <= '0;
        end else begin
            bready     <= 1'b1;
            outst      <= outst + OW'(aw_hs) - OW'(b_hs);
            err_status <= err_status | {bresp_ev, frame_ev, bad_ev};
            err_count  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule

// File: tb/tb_rdmx_recv_be.sv
// tb_rdmx_recv_be: directed packets with a queue scoreboard checking AW/W traffic and error reporting
module tb_rdmx_recv_be;

    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int BPB = 64;

    typedef logic [DW-1:0]  data_t;
    typedef logic [BPB-1:0] strb_t;
    typedef struct packed { logic [AW-1:0] addr; logic [15:0] plen; } pkt_t;
    typedef struct packed { data_t data; logic last; } beat_t;
    typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { data_t data; strb_t strb; logic last; } w_t;

    localparam strb_t ONES = '1;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [2:0]  err_status;
    logic [15:0] err_count;
    int          checks = 0;
    int          errors = 0;
    int          aw_seen = 0;
    logic        b_en = 1'b1, aw_rand = 1'b0, w_rand = 1'b0, w_hold = 1'b0;
    logic [1:0]  next_bresp = 2'b00;

    pkt_t       pq[$];
    beat_t      dq[$];
    aw_t        exp_aw[$];
    w_t         exp_w[$];
    logic [1:0] bq[$];

    rdmx_recv_be_if #(.DATA_WBITS(DW), .ADDR_WBITS(AW)) bus ();

    rdmx_recv_be #(.DATA_WBITS(DW), .ADDR_WBITS(AW), .MAX_OUTST(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus),
        .err_status(err_status),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic data_t pat(input int n);
        return {16{32'hC0DE_0000 + 32'(n)}};
    endfunction

    task automatic pkt(input logic [AW-1:0] a, input logic [15:0] p);
        pq.push_back('{addr: a, plen: p});
    endtask

    task automatic beat(input data_t d, input logic l);
        dq.push_back('{data: d, last: l});
    endtask

    task automatic ea(input logic [AW-1:0] a, input logic [7:0] l);
        exp_aw.push_back('{addr: a, len: l});
    endtask

    task automatic ew(input data_t d, input strb_t s, input logic l);
        exp_w.push_back('{data: d, strb: s, last: l});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((pq.size() > 0 || dq.size() > 0 || exp_aw.size() > 0 || exp_w.size() > 0 ||
                (b_en && bq.size() > 0)) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending aw, %0d pending w, expected 0", name, exp_aw.size(), exp_w.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic chk_err(input string name, input logic [2:0] st, input logic [15:0] cnt);
        chk({name, "_err_status"}, DW'(err_status), DW'(st));
        chk({name, "_err_count"}, DW'(err_count), DW'(cnt));
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_awvalid"}, DW'(bus.M_AXI_AWVALID), '0);
        chk({name, "_wvalid"}, DW'(bus.M_AXI_WVALID), '0);
        chk({name, "_addr_tready"}, DW'(bus.AXIS_ADDR_TREADY), '0);
        chk({name, "_plen_tready"}, DW'(bus.AXIS_PLEN_TREADY), '0);
        chk({name, "_data_tready"}, DW'(bus.AXIS_DATA_TREADY), '0);
        chk({name, "_bready"}, DW'(bus.M_AXI_BREADY), '0);
        chk_err(name, 3'b000, 16'd0);
    endtask

    initial begin : addr_drv
        logic hs;
        forever begin
            bus.AXIS_ADDR_TVALID = pq.size() > 0;
            bus.AXIS_PLEN_TVALID = pq.size() > 0;
            bus.AXIS_ADDR_TDATA  = '0;
            bus.AXIS_PLEN_TDATA  = '0;
            if (pq.size() > 0) begin
                bus.AXIS_ADDR_TDATA = pq[0].addr;
                bus.AXIS_PLEN_TDATA = pq[0].plen;
            end
            @(negedge clk);
            hs = bus.AXIS_ADDR_TVALID && bus.AXIS_ADDR_TREADY;
            @(posedge clk);
            #1;
            if (hs && pq.size() > 0) void'(pq.pop_front());
        end
    end

    initial begin : data_drv
        logic hs;
        forever begin
            bus.AXIS_DATA_TVALID = dq.size() > 0;
            bus.AXIS_DATA_TDATA  = '0;
            bus.AXIS_DATA_TLAST  = 1'b0;
            if (dq.size() > 0) begin
                bus.AXIS_DATA_TDATA = dq[0].data;
                bus.AXIS_DATA_TLAST = dq[0].last;
            end
            @(negedge clk);
            hs = bus.AXIS_DATA_TVALID && bus.AXIS_DATA_TREADY;
            @(posedge clk);
            #1;
            if (hs && dq.size() > 0) void'(dq.pop_front());
        end
    end

    initial begin : ready_drv
        forever begin
            bus.M_AXI_AWREADY = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.M_AXI_WREADY  = w_hold ? 1'b0 : w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
        end
    end

    initial begin : b_drv
        logic hs;
        forever begin
            bus.M_AXI_BVALID = b_en && bq.size() > 0;
            bus.M_AXI_BRESP  = 2'b00;
            if (bq.size() > 0) bus.M_AXI_BRESP = bq[0];
            @(negedge clk);
            hs = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
            @(posedge clk);
            #1;
            if (hs && bq.size() > 0) void'(bq.pop_front());
        end
    end

    always @(negedge clk) begin : mon
        aw_t ea_v;
        w_t  ew_v;
        if (resetn && bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
            aw_seen++;
            bq.push_back(next_bresp);
            if (exp_aw.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL aw_unexpected: got addr %0h, expected no burst", bus.M_AXI_AWADDR);
            end else begin
                ea_v = exp_aw.pop_front();
                chk("awaddr", DW'(bus.M_AXI_AWADDR), DW'(ea_v.addr));
                chk("awlen", DW'(bus.M_AXI_AWLEN), DW'(ea_v.len));
                chk("awsize", DW'(bus.M_AXI_AWSIZE), DW'(3'd6));
                chk("awburst", DW'(bus.M_AXI_AWBURST), DW'(2'b01));
            end
        end
        if (resetn && bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
            if (exp_w.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w_unexpected: got wstrb %0h, expected no beat", bus.M_AXI_WSTRB);
            end else begin
                ew_v = exp_w.pop_front();
                chk("wdata", bus.M_AXI_WDATA, ew_v.data);
                chk("wstrb", DW'(bus.M_AXI_WSTRB), DW'(ew_v.strb));
                chk("wlast", DW'(bus.M_AXI_WLAST), DW'(ew_v.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        #2 resetn = 1'b0;
        #1 chk_reset("init");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // two full beats
        pkt(64'h1000, 16'd128);
        beat(pat(1), 1'b0);
        beat(pat(2), 1'b1);
        ea(64'h1000, 8'd1);
        ew(pat(1), ONES, 1'b0);
        ew(pat(2), ONES, 1'b1);
        wait_done("t1");
        chk_err("t1", 3'b000, 16'd0);

        // partial final beat: 100 bytes leaves 36 on beat 1
        pkt(64'h2000, 16'd100);
        beat(pat(3), 1'b0);
        beat(pat(4), 1'b1);
        ea(64'h2000, 8'd1);
        ew(pat(3), ONES, 1'b0);
        ew(pat(4), 64'h0000_000F_FFFF_FFFF, 1'b1);
        wait_done("t2");

        // maximum burst of 256 beats
        pkt(64'h4_0000, 16'd16384);
        ea(64'h4_0000, 8'd255);
        for (int i = 0; i < 256; i++) begin
            beat(pat(100 + i), 1'(i == 255));
            ew(pat(100 + i), ONES, 1'(i == 255));
        end
        wait_done("tmax");
        chk_err("tmax", 3'b000, 16'd0);

        // zero length drains three beats
        pkt(64'h2100, 16'd0);
        beat(pat(5), 1'b0);
        beat(pat(6), 1'b0);
        beat(pat(7), 1'b1);
        wait_done("t3");
        chk_err("t3", 3'b001, 16'd1);

        // one byte over the maximum length
        pkt(64'h2200, 16'd16385);
        beat(pat(8), 1'b1);
        wait_done("t3b");
        chk_err("t3b", 3'b001, 16'd2);

        // early TLAST pads remaining beat, next packet clean
        pkt(64'h3000, 16'd192);
        beat(pat(20), 1'b0);
        beat(pat(21), 1'b1);
        ea(64'h3000, 8'd2);
        ew(pat(20), ONES, 1'b0);
        ew(pat(21), ONES, 1'b0);
        ew('0, '0, 1'b1);
        pkt(64'h3100, 16'd64);
        beat(pat(22), 1'b1);
        ea(64'h3100, 8'd0);
        ew(pat(22), ONES, 1'b1);
        wait_done("t4");
        chk_err("t4", 3'b011, 16'd3);

        // missing TLAST on the final beat drains the rest
        pkt(64'h3200, 16'd64);
        beat(pat(23), 1'b0);
        beat(pat(24), 1'b1);
        ea(64'h3200, 8'd0);
        ew(pat(23), ONES, 1'b1);
        wait_done("t4b");
        chk_err("t4b", 3'b011, 16'd4);

        // error response on B
        next_bresp = 2'b10;
        pkt(64'h5000, 16'd64);
        beat(pat(30), 1'b1);
        ea(64'h5000, 8'd0);
        ew(pat(30), ONES, 1'b1);
        wait_done("tb");
        next_bresp = 2'b00;
        chk_err("tb", 3'b111, 16'd5);

        // outstanding limit: ninth packet waits for a B
        b_en = 1'b0;
        aw_seen = 0;
        for (int i = 0; i < 9; i++) begin
            pkt(64'h1_0000 + 64'(i * 64), 16'd64);
            beat(pat(40 + i), 1'b1);
            ea(64'h1_0000 + 64'(i * 64), 8'd0);
            ew(pat(40 + i), ONES, 1'b1);
        end
        n = 0;
        while (aw_seen < 8 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("t5_aw_held", DW'(aw_seen), DW'(8));
        chk("t5_pkt_pending", DW'(pq.size()), DW'(1));
        chk("t5_addr_tready", DW'(bus.AXIS_ADDR_TREADY), '0);
        b_en = 1'b1;
        wait_done("t5");
        chk("t5_aw_total", DW'(aw_seen), DW'(9));
        chk_err("t5", 3'b111, 16'd5);

        // random backpressure, then reset in the middle of W
        aw_rand = 1'b1;
        w_rand = 1'b1;
        pkt(64'h6000, 16'd256);
        ea(64'h6000, 8'd3);
        for (int i = 0; i < 4; i++) begin
            beat(pat(60 + i), 1'(i == 3));
            ew(pat(60 + i), ONES, 1'(i == 3));
        end
        wait_done("t6a");
        w_hold = 1'b1;
        pkt(64'h7000, 16'd128);
        beat(pat(70), 1'b0);
        beat(pat(71), 1'b1);
        ea(64'h7000, 8'd1);
        ew(pat(70), ONES, 1'b0);
        ew(pat(71), ONES, 1'b1);
        n = 0;
        while (!bus.M_AXI_WVALID && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wvalid_before_reset", DW'(bus.M_AXI_WVALID), DW'(1'b1));
        @(posedge clk);
        #3 resetn = 1'b0;
        #1 chk_reset("t6_mid");
        pq.delete();
        dq.delete();
        exp_aw.delete();
        exp_w.delete();
        bq.delete();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        w_hold = 1'b0;
        pkt(64'h8000, 16'd130);
        ea(64'h8000, 8'd2);
        beat(pat(80), 1'b0);
        beat(pat(81), 1'b0);
        beat(pat(82), 1'b1);
        ew(pat(80), ONES, 1'b0);
        ew(pat(81), ONES, 1'b0);
        ew(pat(82), 64'h3, 1'b1);
        wait_done("t6b");
        chk_err("t6b", 3'b000, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
